// File: rtl/usb_rx_checker_if.sv
// Receive-side stream bundle between the USB FIFO gateway and a sink.
// The gateway (master) presents valid/data; the sink (slave) returns ready.
interface usb_rx_checker_if #(
  parameter int DATA_W = 32
) ();

  logic              rx_valid_in;
  logic [DATA_W-1:0] rx_data_in;
  logic              rx_ready_out;

  modport master (
    output rx_valid_in,
    output rx_data_in,
    input  rx_ready_out
  );

  modport slave (
    input  rx_valid_in,
    input  rx_data_in,
    output rx_ready_out
  );

endinterface

// File: rtl/usb_rx_checker.sv
// Incrementing-counter pattern checker for the host-to-FPGA stream.
// Accepts words from the gateway, tracks lock to the counter sequence and
// keeps word / error statistics plus a capture of the first mismatch.
module usb_rx_checker #(
  parameter int DATA_W   = 32,
  parameter int ERR_W    = 16,
  parameter int LOSS_CNT = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               enable_in,
  input  logic               clear_in,
  usb_rx_checker_if.slave    rx,
  output logic [31:0]        words_out,
  output logic [ERR_W-1:0]   errors_out,
  output logic               locked_out,
  output logic               error_out,
  output logic [DATA_W-1:0]  first_exp_out,
  output logic [DATA_W-1:0]  first_got_out
);

  // LOSS_CNT is at most 15, so a 4-bit run counter never overflows.
  localparam int                MISS_W   = 4;
  localparam logic [MISS_W-1:0] LOSS_LIM = MISS_W'(LOSS_CNT);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic               ready_q;
  logic [DATA_W-1:0]  expected;
  logic [MISS_W-1:0]  miss_run;
  logic [MISS_W-1:0]  miss_inc;

  logic               xfer;
  logic               match;
  logic               mismatch;
  logic               loss;
  logic [DATA_W-1:0]  data_inc;

  // Error counter holds at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (&v) r = v;
    else    r = v + ERR_W'(1);
    return r;
  endfunction

  assign rx.rx_ready_out = ready_q;

  // Transfer qualification and compare against the expected counter value.
  always_comb begin
    xfer     = rx.rx_valid_in & ready_q;
    match    = (rx.rx_data_in == expected);
    mismatch = xfer & (state == ST_LOCKED) & ~match;
    miss_inc = miss_run + MISS_W'(1);
    loss     = mismatch & (miss_inc == LOSS_LIM);
    data_inc = rx.rx_data_in + DATA_ONE;
  end

  // Ready is enable delayed by one cycle; clear does not touch it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) ready_q <= 1'b0;
    else        ready_q <= enable_in;
  end

  // Lock state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= ST_SYNC;
    else        state <= state_nxt;
  end

  // Next lock state: first word seeds the counter, a run of misses drops lock.
  always_comb begin
    state_nxt = state;
    if (clear_in) begin
      state_nxt = ST_SYNC;
    end else if (xfer) begin
      case (state)
        ST_SYNC:   state_nxt = ST_LOCKED;
        ST_LOCKED: if (loss) state_nxt = ST_SYNC;
        default:   state_nxt = ST_SYNC;
      endcase
    end
  end

  // Lock indication decoded from the state register.
  always_comb begin
    locked_out = (state == ST_LOCKED);
  end

  // Expected value tracking and consecutive-miss run; mismatches resync.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      expected <= '0;
      miss_run <= '0;
    end else if (clear_in) begin
      miss_run <= '0;
    end else if (xfer) begin
      if (state == ST_SYNC) begin
        expected <= data_inc;
        miss_run <= '0;
      end else if (match) begin
        expected <= expected + DATA_ONE;
        miss_run <= '0;
      end else begin
        expected <= data_inc;
        miss_run <= loss ? '0 : miss_inc;
      end
    end
  end

  // Word and error statistics; clear takes priority over a coincident word.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      words_out  <= '0;
      errors_out <= '0;
    end else if (clear_in) begin
      words_out  <= '0;
      errors_out <= '0;
    end else if (xfer) begin
      words_out <= words_out + 32'd1;
      if (mismatch) errors_out <= sat_inc(errors_out);
    end
  end

  // Sticky error flag with capture of the first mismatching pair.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      error_out     <= 1'b0;
      first_exp_out <= '0;
      first_got_out <= '0;
    end else if (clear_in) begin
      error_out     <= 1'b0;
      first_exp_out <= '0;
      first_got_out <= '0;
    end else if (mismatch && !error_out) begin
      error_out     <= 1'b1;
      first_exp_out <= expected;
      first_got_out <= rx.rx_data_in;
    end
  end

endmodule
